// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one uart_tx among NUM_REQ byte streams.
// Holds a grant for a whole packet (capped at MAX_BURST bytes) and sequences send/ready.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_BURST     = 16,
    parameter int FETCH_TIMEOUT = 255,
    parameter int ID_W          = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_send,
    input  logic                 tx_ready,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id,
    output logic                 abort_pulse
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND, WAIT} state_t;
    state_t          state, state_n;
    logic [ID_W-1:0] rr, rr_n, grant_id_n, pick, idx;
    logic            pick_ok, sel_valid, last_q, last_n, tx_send_n, grant_valid_n, abort_n;
    logic [7:0]      byte_cnt, byte_cnt_n, tx_data_n;
    logic [15:0]     timeout_cnt, timeout_cnt_n;

    assign sel_valid = req_valid[grant_id];
    assign req_ready = (state == FETCH && sel_valid) ? (NUM_REQ'(1) << grant_id) : '0;

    // Scan farthest-first so the requester nearest after rr overwrites and wins.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        idx     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(rr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_n       = state;
        rr_n          = rr;
        grant_id_n    = grant_id;
        grant_valid_n = grant_valid;
        byte_cnt_n    = byte_cnt;
        timeout_cnt_n = timeout_cnt;
        tx_data_n     = tx_data;
        last_n        = last_q;
        tx_send_n     = tx_send;
        abort_n       = 1'b0;
        unique case (state)
            IDLE: if (pick_ok) begin
                grant_id_n    = pick;
                grant_valid_n = 1'b1;
                byte_cnt_n    = '0;
                timeout_cnt_n = '0;
                state_n       = FETCH;
            end
            FETCH: if (sel_valid) begin
                tx_data_n     = req_data[{grant_id, 3'b000} +: 8];
                last_n        = req_last[grant_id];
                timeout_cnt_n = '0;
                tx_send_n     = 1'b1;
                state_n       = SEND;
            end else if (timeout_cnt == 16'(FETCH_TIMEOUT - 1)) begin
                abort_n       = 1'b1;
                rr_n          = grant_id;
                grant_valid_n = 1'b0;
                grant_id_n    = '0;
                timeout_cnt_n = '0;
                state_n       = IDLE;
            end else begin
                timeout_cnt_n = timeout_cnt + 16'd1;
            end
            SEND: if (!tx_ready) begin
                tx_send_n = 1'b0;
                state_n   = WAIT;
            end
            WAIT: if (tx_ready) begin
                byte_cnt_n = byte_cnt + 8'd1;
                // A burst-cap release mid-packet is fine: the requester re-arbitrates later.
                if (last_q || ({1'b0, byte_cnt} + 9'd1 == 9'(MAX_BURST))) begin
                    rr_n          = grant_id;
                    grant_valid_n = 1'b0;
                    grant_id_n    = '0;
                    state_n       = IDLE;
                end else begin
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr          <= ID_W'(NUM_REQ - 1);
            grant_id    <= '0;
            grant_valid <= 1'b0;
            byte_cnt    <= '0;
            timeout_cnt <= '0;
            tx_data     <= '0;
            last_q      <= 1'b0;
            tx_send     <= 1'b0;
            abort_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            rr          <= rr_n;
            grant_id    <= grant_id_n;
            grant_valid <= grant_valid_n;
            byte_cnt    <= byte_cnt_n;
            timeout_cnt <= timeout_cnt_n;
            tx_data     <= tx_data_n;
            last_q      <= last_n;
            tx_send     <= tx_send_n;
            abort_pulse <= abort_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed tests for uart_tx_arbiter with queue-fed requesters and
// a behavioural uart_tx (ready drops 2 cycles after send, returns 20 cycles later).
module tb_uart_tx_arbiter;
    localparam int N = 4;
    logic           clk = 1'b0, rst = 1'b1;
    logic [N-1:0]   req_valid = '0, req_last = '0, req_ready;
    logic [8*N-1:0] req_data = '0;
    logic [7:0]     tx_data;
    logic           tx_send, tx_ready = 1'b1;
    logic           grant_valid, abort_pulse;
    logic [1:0]     grant_id;
    int             tests = 0, fails = 0, frames_done = 0;
    logic           stall = 1'b0;
    logic [N-1:0]   en = '1;
    logic [8:0]     src [N][$];
    logic [10:0]    acc_log [$];
    logic [7:0]     tx_log [$];

    uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(16), .FETCH_TIMEOUT(10), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_data(tx_data), .tx_send(tx_send), .tx_ready(tx_ready),
        .grant_valid(grant_valid), .grant_id(grant_id), .abort_pulse(abort_pulse)
    );

    always #5 clk = ~clk;

    // Requester sources: log accepted bytes at the edge, present the next head 1 ns later.
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i] && !rst) begin
                acc_log.push_back({2'(i), req_last[i], req_data[8*i +: 8]});
                src[i].delete(0);
            end
        #1;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = en[i] && src[i].size() > 0;
            req_last[i]        = src[i].size() > 0 ? src[i][0][8] : 1'b0;
            req_data[8*i +: 8] = src[i].size() > 0 ? src[i][0][7:0] : 8'h00;
        end
    end

    initial begin : uart_model
        int   cnt;
        logic busy;
        cnt  = 0;
        busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_ready = 1'b1;
                cnt      = 0;
                busy     = 1'b0;
            end else if (!busy) begin
                if (tx_send && !stall) begin
                    cnt++;
                    if (cnt == 2) begin
                        tx_ready = 1'b0;
                        busy     = 1'b1;
                        cnt      = 0;
                        tx_log.push_back(tx_data);
                    end
                end else cnt = 0;
            end else begin
                cnt++;
                if (cnt == 20) begin
                    tx_ready = 1'b1;
                    busy     = 1'b0;
                    cnt      = 0;
                    frames_done++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        stall = 1'b0;
        en    = '1;
        for (int i = 0; i < N; i++) src[i].delete();
        acc_log.delete();
        tx_log.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic bad;
        rst = 1'b1;
        tick();
        tick();
        tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        tests++; if (tx_send !== 1'b0) begin fails++; $display("FAIL reset_tx_send got %b want 0", tx_send); end
        tests++; if (req_ready !== 4'h0) begin fails++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        tests++; if (grant_valid !== 1'b0) begin fails++; $display("FAIL reset_grant_valid got %b want 0", grant_valid); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
        tests++; if (abort_pulse !== 1'b0) begin fails++; $display("FAIL reset_abort got %b want 0", abort_pulse); end
        rst = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            tick();
            if (grant_valid !== 1'b0 || req_ready !== 4'h0) bad = 1'b1;
        end
        tests++; if (bad) begin fails++; $display("FAIL idle_no_grant got grant without request want none"); end
    endtask

    task automatic test_single();
        logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
        int   base;
        logic prev_gv, bad_id, done;
        do_reset();
        base    = frames_done;
        bad_id  = 1'b0;
        done    = 1'b0;
        prev_gv = 1'b0;
        src[2].push_back({1'b0, 8'h41});
        src[2].push_back({1'b0, 8'h42});
        src[2].push_back({1'b1, 8'h43});
        for (int c = 0; c < 400 && !done; c++) begin
            prev_gv = grant_valid;
            tick();
            if (frames_done == base + 3) done = 1'b1;
            else if (grant_valid && grant_id !== 2'd2) bad_id = 1'b1;
        end
        tests++; if (!done) begin fails++; $display("FAIL single_timeout got %0d frames want 3", frames_done - base); end
        tests++; if (prev_gv !== 1'b1 || grant_valid !== 1'b0) begin
            fails++; $display("FAIL single_release got prev=%b now=%b want prev=1 now=0", prev_gv, grant_valid);
        end
        tests++; if (bad_id) begin fails++; $display("FAIL single_grant_id got other id want 2"); end
        tests++; if (tx_log.size() != 3) begin fails++; $display("FAIL single_tx_count got %0d want 3", tx_log.size()); end
        for (int i = 0; i < 3 && i < tx_log.size(); i++) begin
            tests++; if (tx_log[i] !== exp[i]) begin fails++; $display("FAIL single_tx_data[%0d] got %h want %h", i, tx_log[i], exp[i]); end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        do_reset();
        for (int k = 0; k < 2; k++) begin
            src[0].push_back({1'b1, 8'h10 + 8'(k)});
            src[1].push_back({1'b1, 8'h20 + 8'(k)});
            src[3].push_back({1'b1, 8'h30 + 8'(k)});
        end
        for (int c = 0; c < 1000 && acc_log.size() < 6; c++) tick();
        tests++; if (acc_log.size() < 6) begin fails++; $display("FAIL rr_timeout got %0d bytes want 6", acc_log.size()); end
        for (int i = 0; i < 6 && i < acc_log.size(); i++) begin
            tests++; if (acc_log[i][10:9] !== exp[i]) begin fails++; $display("FAIL rr_order[%0d] got %0d want %0d", i, acc_log[i][10:9], exp[i]); end
        end
    endtask

    task automatic test_burst();
        logic [9:0] exp [$];
        logic       bad;
        do_reset();
        for (int k = 0; k < 20; k++) src[1].push_back({k == 19, 8'h80 + 8'(k)});
        for (int k = 0; k < 16; k++) exp.push_back({2'd1, 8'h80 + 8'(k)});
        exp.push_back({2'd2, 8'hC0});
        exp.push_back({2'd2, 8'hC1});
        for (int k = 16; k < 20; k++) exp.push_back({2'd1, 8'h80 + 8'(k)});
        for (int c = 0; c < 100 && acc_log.size() < 1; c++) tick();
        src[2].push_back({1'b0, 8'hC0});
        src[2].push_back({1'b1, 8'hC1});
        for (int c = 0; c < 3000 && acc_log.size() < 22; c++) tick();
        tests++; if (acc_log.size() != 22) begin fails++; $display("FAIL burst_count got %0d want 22", acc_log.size()); end
        bad = 1'b0;
        for (int i = 0; i < 22 && i < acc_log.size(); i++)
            if ({acc_log[i][10:9], acc_log[i][7:0]} !== exp[i]) begin
                bad = 1'b1;
                $display("FAIL burst_seq[%0d] got id%0d/%h want id%0d/%h", i, acc_log[i][10:9], acc_log[i][7:0], exp[i][9:8], exp[i][7:0]);
            end
        tests++; if (bad) fails++;
        tests++; if (acc_log.size() > 18 && acc_log[18][7:0] !== 8'h90) begin
            fails++; $display("FAIL burst_resume got %h want 90", acc_log[18][7:0]);
        end
    endtask

    task automatic test_timeout();
        int base, n;
        do_reset();
        base = frames_done;
        src[0].push_back({1'b0, 8'h55});
        for (int c = 0; c < 100 && acc_log.size() < 1; c++) tick();
        src[1].push_back({1'b1, 8'h66});
        for (int c = 0; c < 100 && frames_done == base; c++) tick();
        n = 0;
        while (!abort_pulse && n < 20) begin
            tick();
            n++;
        end
        tests++; if (n != 10) begin fails++; $display("FAIL timeout_cycles got %0d want 10", n); end
        tests++; if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin
            fails++; $display("FAIL timeout_release got gv=%b id=%0d want gv=0 id=0", grant_valid, grant_id);
        end
        tick();
        tests++; if (abort_pulse !== 1'b0) begin fails++; $display("FAIL timeout_pulse_width got %b want 0", abort_pulse); end
        for (int c = 0; c < 100 && acc_log.size() < 2; c++) tick();
        tests++; if (acc_log.size() < 2 || acc_log[1][10:9] !== 2'd1 || acc_log[1][7:0] !== 8'h66) begin
            fails++; $display("FAIL timeout_next_grant got %0d entries want req1 byte 66", acc_log.size());
        end
    endtask

    task automatic test_stall();
        logic bad_send, bad_data, bad_ready;
        do_reset();
        stall = 1'b1;
        src[3].push_back({1'b0, 8'h5A});
        src[3].push_back({1'b1, 8'h5B});
        for (int c = 0; c < 20 && !tx_send; c++) tick();
        tests++; if (tx_send !== 1'b1) begin fails++; $display("FAIL stall_send_start got %b want 1", tx_send); end
        bad_send  = 1'b0;
        bad_data  = 1'b0;
        bad_ready = 1'b0;
        repeat (50) begin
            tick();
            if (tx_send !== 1'b1) bad_send = 1'b1;
            if (tx_data !== 8'h5A) bad_data = 1'b1;
            if (req_ready !== 4'h0) bad_ready = 1'b1;
        end
        tests++; if (bad_send) begin fails++; $display("FAIL stall_send_held got drop want held 1"); end
        tests++; if (bad_data) begin fails++; $display("FAIL stall_data_held got change want 5a"); end
        tests++; if (bad_ready) begin fails++; $display("FAIL stall_no_ready got req_ready want 0000"); end
        stall = 1'b0;
        for (int c = 0; c < 200 && !(acc_log.size() == 2 && tx_log.size() == 2); c++) tick();
        tests++; if (acc_log.size() != 2 || tx_log.size() != 2 || tx_log[0] !== 8'h5A || tx_log[1] !== 8'h5B) begin
            fails++; $display("FAIL stall_resume got acc=%0d tx=%0d want 2 bytes 5a,5b", acc_log.size(), tx_log.size());
        end
    endtask

    task automatic test_reset_mid_wait();
        logic bad;
        do_reset();
        src[0].push_back({1'b1, 8'hA5});
        for (int c = 0; c < 50 && tx_log.size() < 1; c++) tick();
        tick();
        tests++; if (grant_valid !== 1'b1 || tx_data !== 8'hA5 || tx_send !== 1'b0) begin
            fails++; $display("FAIL midwait_setup got gv=%b data=%h send=%b want 1/a5/0", grant_valid, tx_data, tx_send);
        end
        #2 rst = 1'b1;
        #1;
        tests++; if ({tx_data, tx_send, grant_valid, grant_id, abort_pulse, req_ready} !== '0) begin
            fails++; $display("FAIL midwait_async got data=%h send=%b gv=%b id=%0d ab=%b rdy=%b want all 0",
                              tx_data, tx_send, grant_valid, grant_id, abort_pulse, req_ready);
        end
        tick();
        rst = 1'b0;
        acc_log.delete();
        bad = 1'b0;
        repeat (5) begin
            tick();
            if (req_ready !== 4'h0 || grant_valid !== 1'b0) bad = 1'b1;
        end
        tests++; if (bad) begin fails++; $display("FAIL midwait_quiet got activity want idle"); end
        src[2].push_back({1'b1, 8'h77});
        for (int c = 0; c < 50 && acc_log.size() < 1; c++) tick();
        tests++; if (acc_log.size() < 1 || acc_log[0][10:9] !== 2'd2 || acc_log[0][7:0] !== 8'h77) begin
            fails++; $display("FAIL midwait_recover got %0d entries want req2 byte 77", acc_log.size());
        end
        for (int c = 0; c < 50 && grant_valid; c++) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_timeout();
        test_stall();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between NUM_REQ independent byte-stream requesters.
- Each requester presents bytes on a valid/ready interface with a last-byte marker.
- The arbiter grants one requester at a time in round-robin order and holds the grant for a whole packet, capped by MAX_BURST bytes.
- It sequences the transmitter's send/ready handshake, keeping data stable until each frame completes. It sits between software-facing FIFOs and uart_tx.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- MAX_BURST, 16: maximum bytes per grant before forced release; 1..255.
- FETCH_TIMEOUT, 255: cycles the granted requester may leave valid low in FETCH before the grant is dropped; 1..65535.
- ID_W, 2: width of grant_id; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- req_valid, in, NUM_REQ: per-requester byte valid.
- req_data, in, 8*NUM_REQ: requester i uses bits [8i+7:8i].
- req_last, in, NUM_REQ: marks the final byte of a packet; qualified by valid.
- req_ready, out, NUM_REQ: one-hot (or zero) byte accept.
- tx_data, out, 8: byte to uart_tx data input.
- tx_send, out, 1: to uart_tx send.
- tx_ready, in, 1: from uart_tx ready; high means idle.
- grant_valid, out, 1: a requester currently holds the grant.
- grant_id, out, ID_W: index of the granted requester; 0 when none.
- abort_pulse, out, 1: one-cycle pulse when a grant is dropped by timeout.

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE, rr pointer=NUM_REQ-1, byte_cnt=0, timeout_cnt=0.
  - tx_data=0, tx_send=0, req_ready=0, grant_valid=0, grant_id=0, abort_pulse=0.
- Reset mid-frame abandons the byte. uart_tx has its own reset and is not sequenced here.
- All outputs are registered except req_ready, which is combinational from state, grant_id and req_valid.
- IDLE:
  - If any req_valid is set, select the first set bit searching from rr+1 upward with wrap modulo NUM_REQ.
  - Register grant_id, set grant_valid=1, clear byte_cnt and timeout_cnt, go to FETCH. This costs 1 cycle of arbitration latency.
  - If no request is pending, stay in IDLE.
- FETCH:
  - req_ready[grant_id]=req_valid[grant_id]. On that handshake, latch tx_data and last_q, clear timeout_cnt, go to SEND.
  - Otherwise increment timeout_cnt. When timeout_cnt reaches FETCH_TIMEOUT-1 with valid still low: pulse abort_pulse, set rr=grant_id, grant_valid=0, go to IDLE.
- SEND:
  - tx_send=1; tx_data is held.
  - When tx_ready is sampled 0 (transmitter started), set tx_send=0 and go to WAIT.
  - tx_send stays high indefinitely while tx_ready stays 1.
- WAIT:
  - tx_data is held.
  - When tx_ready is sampled 1 (frame done), increment byte_cnt.
  - If last_q is set, or byte_cnt+1 == MAX_BURST: set rr=grant_id, grant_valid=0, go to IDLE.
  - Otherwise go to FETCH, keeping the grant.
- Round-robin: rr updates only on release, so after a release the released requester has lowest priority.
- Only one requester ever sees req_ready=1 in a given cycle. A non-granted requester's valid never affects the current grant.
- req_last on a non-accepted cycle is ignored.
- A MAX_BURST release mid-packet is legal. The requester re-arbitrates and continues the packet in a later grant.
- Pointer wrap: with rr=NUM_REQ-1, the search starts at 0.
- Back-to-back throughput: one byte per UART frame plus 2 cycles (FETCH + SEND detect).

Test Plan:
- Reset in each state; rst pulsed asynchronously mid-WAIT -> all outputs 0 on the same edge, state IDLE, no req_ready afterwards until a valid arrives.
- Only req 2 valid, 3-byte packet 0x41,0x42,0x43 with last on 0x43, uart model (ready drops 2 cycles after send, returns 20 cycles later) -> tx_data sequence 0x41,0x42,0x43; grant_id=2 throughout; grant_valid falls the cycle after the third ready rise.
- Reqs 0,1,3 all continuously valid, 1-byte packets, starting from reset -> grant order 0,1,3,0,1,3.
- Req 1 sends a 20-byte packet with MAX_BURST=16 while req 2 waits -> req 1 gets 16 bytes, req 2 gets its packet, then req 1 resumes with byte 17.
- Req 0 granted, sends 1 byte without last, then drops valid, FETCH_TIMEOUT=10 -> abort_pulse exactly 10 cycles after entering FETCH, grant_valid=0, next grant goes to the waiting req 1.
- tx_ready held at 1 for 50 cycles in SEND (stalled transmitter) -> tx_send stays 1 and tx_data stays stable; no second req_ready until the ready fall/rise pair is seen.
